// File: rtl/rc4_pkg.sv
// Shared RC4 definitions used by the init, shuffle and decrypt stages:
// PRGA state encoding, array sizes and the printable-text range.
package rc4_pkg;

   localparam int KEY_BYTES = 3;
   localparam int S_SIZE    = 256;

   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_LO    = 8'h61;
   localparam logic [7:0] ASCII_HI    = 8'h7A;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_INC_I,
      ST_WAIT_SI,
      ST_CALC_J,
      ST_ADDR_SJ,
      ST_WAIT_SJ,
      ST_LATCH_SJ,
      ST_WR_I,
      ST_WR_J,
      ST_ADDR_F,
      ST_WAIT_F,
      ST_WR_OUT,
      ST_NEXT,
      ST_DONE
   } state_t;

   function automatic logic is_printable(input logic [7:0] b);
      return (b == ASCII_SPACE) || ((b >= ASCII_LO) && (b <= ASCII_HI));
   endfunction

endpackage

// File: rtl/rc4_decrypt_rd_wait_cnt.sv
// Loadable down-counter timing the memory read latency; last is high in the
// final cycle of a wait.
module rd_wait_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         last
);

   localparam logic [W-1:0] ONE = W'(1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!reset_n)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - ONE;
   end

   assign last = (cnt == ONE);

endmodule

// File: rtl/rc4_decrypt.sv
// RC4 PRGA + decryption: walks S with the i/j swap, XORs the keystream with
// the ROM ciphertext and writes plaintext. Optional DECRYPT_ASCII_CHECK_EN
// aborts on the first non-lowercase/space plaintext byte.
module rc4_decrypt
   import rc4_pkg::*;
#(
   parameter int MSG_LEN = 32,
   parameter int RD_WAIT = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       ack,
   output logic       finished,
   output logic [7:0] s_addr,
   output logic [7:0] s_wrdata,
   output logic       s_wren,
   input  logic [7:0] s_rddata,
   output logic [7:0] rom_addr,
   input  logic [7:0] rom_rddata,
   output logic [7:0] out_addr,
   output logic [7:0] out_wrdata,
   output logic       out_wren,
   output logic       bad_key
);

   localparam logic [7:0] K_LAST   = 8'(MSG_LEN - 1);
   localparam logic [7:0] WAIT_LD  = 8'(RD_WAIT);
   localparam bit         HAS_WAIT = (RD_WAIT > 0);

   state_t     state, state_n;
   logic [7:0] i, j, k, si, sj, enc;
   logic [7:0] i_n, j_n, k_n, si_n, sj_n, enc_n;
   logic [7:0] pt_n;
   logic       wait_load, wait_last;

`ifdef DECRYPT_ASCII_CHECK_EN
   logic bad_set;
`endif

   rd_wait_cnt #(.W(8)) u_wait (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (wait_load),
      .load_val (WAIT_LD),
      .last     (wait_last)
   );

   always_comb begin
      state_n   = state;
      i_n       = i;
      j_n       = j;
      k_n       = k;
      si_n      = si;
      sj_n      = sj;
      enc_n     = enc;
      wait_load = 1'b0;
`ifdef DECRYPT_ASCII_CHECK_EN
      bad_set   = 1'b0;
`endif
      case (state)
         ST_IDLE: begin
            i_n   = '0;
            j_n   = '0;
            k_n   = '0;
            si_n  = '0;
            sj_n  = '0;
            enc_n = '0;
            if (start) state_n = ST_INC_I;
         end
         ST_INC_I: begin
            i_n = i + 8'd1;
            if (HAS_WAIT) begin
               state_n   = ST_WAIT_SI;
               wait_load = 1'b1;
            end else begin
               state_n = ST_CALC_J;
            end
         end
         ST_WAIT_SI: if (wait_last) state_n = ST_CALC_J;
         ST_CALC_J: begin
            si_n    = s_rddata;
            enc_n   = rom_rddata;
            j_n     = j + s_rddata;
            state_n = ST_ADDR_SJ;
         end
         ST_ADDR_SJ: begin
            if (HAS_WAIT) begin
               state_n   = ST_WAIT_SJ;
               wait_load = 1'b1;
            end else begin
               state_n = ST_LATCH_SJ;
            end
         end
         ST_WAIT_SJ: if (wait_last) state_n = ST_LATCH_SJ;
         ST_LATCH_SJ: begin
            sj_n    = s_rddata;
            state_n = ST_WR_I;
         end
         ST_WR_I: state_n = ST_WR_J;
         ST_WR_J: state_n = ST_ADDR_F;
         ST_ADDR_F: begin
            if (HAS_WAIT) begin
               state_n   = ST_WAIT_F;
               wait_load = 1'b1;
            end else begin
               state_n = ST_WR_OUT;
            end
         end
         ST_WAIT_F: if (wait_last) state_n = ST_WR_OUT;
         ST_WR_OUT: begin
            state_n = ST_NEXT;
`ifdef DECRYPT_ASCII_CHECK_EN
            if (!is_printable(out_wrdata)) begin
               bad_set = 1'b1;
               state_n = ST_DONE;
            end
`endif
         end
         ST_NEXT: begin
            if (k == K_LAST) begin
               state_n = ST_DONE;
            end else begin
               k_n     = k + 8'd1;
               state_n = ST_INC_I;
            end
         end
         ST_DONE: if (ack) state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   assign pt_n = s_rddata ^ enc_n;

   // Outputs are registered from the state being entered, using the register
   // values that will hold during that state.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         i          <= '0;
         j          <= '0;
         k          <= '0;
         si         <= '0;
         sj         <= '0;
         enc        <= '0;
         finished   <= 1'b0;
         s_addr     <= '0;
         s_wrdata   <= '0;
         s_wren     <= 1'b0;
         rom_addr   <= '0;
         out_addr   <= '0;
         out_wrdata <= '0;
         out_wren   <= 1'b0;
      end else begin
         state    <= state_n;
         i        <= i_n;
         j        <= j_n;
         k        <= k_n;
         si       <= si_n;
         sj       <= sj_n;
         enc      <= enc_n;
         finished <= (state_n == ST_DONE);
         s_wren   <= 1'b0;
         out_wren <= 1'b0;
         case (state_n)
            ST_INC_I: begin
               s_addr   <= i_n + 8'd1;
               rom_addr <= k_n;
            end
            ST_ADDR_SJ: s_addr <= j_n;
            ST_WR_I: begin
               s_addr   <= i_n;
               s_wrdata <= sj_n;
               s_wren   <= 1'b1;
            end
            ST_WR_J: begin
               s_addr   <= j_n;
               s_wrdata <= si_n;
               s_wren   <= 1'b1;
            end
            ST_ADDR_F: s_addr <= si_n + sj_n;
            ST_WR_OUT: begin
               out_addr   <= k_n;
               out_wrdata <= pt_n;
`ifdef DECRYPT_ASCII_CHECK_EN
               out_wren   <= is_printable(pt_n);
`else
               out_wren   <= 1'b1;
`endif
            end
            default: ;
         endcase
      end
   end

`ifdef DECRYPT_ASCII_CHECK_EN
   always_ff @(posedge clk) begin
      if (!reset_n)
         bad_key <= 1'b0;
      else if ((state == ST_IDLE) && (state_n != ST_IDLE))
         bad_key <= 1'b0;
      else if (bad_set)
         bad_key <= 1'b1;
   end
`else
   assign bad_key = 1'b0;
`endif

endmodule
